// File: rtl/csr_trap_if.sv
// CSR access bus between the execute-stage decode (master) and the
// machine-mode CSR/trap unit (slave): operation, operands and read-back.
interface csr_trap_if;
    logic        csr_we;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [31:0] reg1;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        illegal_csr;

    modport master (
        output csr_we,
        output func3,
        output rs1,
        output reg1,
        output csr_addr,
        input  csr_rdata,
        input  illegal_csr
    );

    modport slave (
        input  csr_we,
        input  func3,
        input  rs1,
        input  reg1,
        input  csr_addr,
        output csr_rdata,
        output illegal_csr
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap/interrupt sequencing for a single-hart RV32
// pipeline (execute stage). Supplies CSR read data, trap redirect and mret
// redirect. Optional build macro CSR_COUNTERS_EN adds the 64-bit mcycle and
// minstret counters; without it those addresses read 0 and ignore writes.
module csr_trap_unit #(
    parameter logic [31:0] HART_ID       = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter int          NUM_LOCAL_IRQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    csr_trap_if.slave                bus,
    input  logic                     pipeline_en,
    input  logic [31:0]              pc,
    input  logic                     ecall,
    input  logic                     ebreak,
    input  logic                     mret,
    input  logic                     instr_retire,
    input  logic                     irq_ext,
    input  logic                     irq_timer,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
    output logic                     trap_taken,
    output logic [31:0]              trap_target,
    output logic [31:0]              mret_target
);

    localparam logic [31:0] LOCAL_MASK = ((32'h0000_0001 << NUM_LOCAL_IRQ) - 32'h0000_0001) << 16;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;

    // Architectural state
    logic        mstatus_mie_r;
    logic        mstatus_mpie_r;
    logic [31:0] mie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [31:0] mtval_r;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_r;
    logic [63:0] minstret_r;
`endif

    logic [31:0] mstatus_s;
    logic [31:0] mip_s;
    logic [31:0] pending_s;
    logic        irq_hit_s;
    logic [4:0]  irq_code_s;
    logic        trap_s;
    logic [31:0] trap_cause_s;
    logic [31:0] trap_val_s;
    logic [31:0] rdata_s;
    logic        addr_ok_s;
    logic [31:0] src_s;
    logic        write_attempt_s;
    logic [31:0] wdata_s;
    logic        illegal_s;
    logic        commit_s;

    assign mstatus_s = 32'h0000_1800 | {24'h00_0000, mstatus_mpie_r, 3'b000, mstatus_mie_r, 3'b000};

    // Live pending-interrupt view from the interrupt input levels
    always_comb begin
        mip_s     = 32'h0000_0000;
        mip_s[11] = irq_ext;
        mip_s[7]  = irq_timer;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            mip_s[16+i] = irq_local[i];
        end
    end

    assign pending_s = mie_r & mip_s;

    // Interrupt arbitration: external > timer > lowest-index local line
    always_comb begin
        irq_hit_s  = 1'b0;
        irq_code_s = 5'd0;
        if (mstatus_mie_r && (pending_s != 32'h0000_0000)) begin
            irq_hit_s = 1'b1;
            if (pending_s[11]) begin
                irq_code_s = 5'd11;
            end else if (pending_s[7]) begin
                irq_code_s = 5'd7;
            end else begin
                // Descending scan so the lowest pending index wins
                for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
                    irq_code_s = pending_s[16+i] ? 5'(16 + i) : irq_code_s;
                end
            end
        end else begin
            irq_hit_s  = 1'b0;
            irq_code_s = 5'd0;
        end
    end

    // Trap selection, cause/tval and redirect target
    always_comb begin
        trap_s       = pipeline_en && (ebreak || ecall || irq_hit_s);
        trap_cause_s = 32'h0000_0000;
        trap_val_s   = 32'h0000_0000;
        trap_target  = {mtvec_r[31:2], 2'b00};
        if (ebreak) begin
            trap_cause_s = 32'd3;
            trap_val_s   = pc;
        end else if (ecall) begin
            trap_cause_s = 32'd11;
        end else begin
            trap_cause_s = {1'b1, 26'h000_0000, irq_code_s};
            if (mtvec_r[0]) begin
                trap_target = {mtvec_r[31:2], 2'b00} + {25'h000_0000, irq_code_s, 2'b00};
            end else begin
                trap_target = {mtvec_r[31:2], 2'b00};
            end
        end
    end

    assign trap_taken  = trap_s;
    assign mret_target = mepc_r;

    // Address decode and old-value read mux
    always_comb begin
        rdata_s   = 32'h0000_0000;
        addr_ok_s = 1'b1;
        case (bus.csr_addr)
            12'h300: rdata_s = mstatus_s;
            12'h304: rdata_s = mie_r;
            12'h305: rdata_s = mtvec_r;
            12'h340: rdata_s = mscratch_r;
            12'h341: rdata_s = mepc_r;
            12'h342: rdata_s = mcause_r;
            12'h343: rdata_s = mtval_r;
            12'h344: rdata_s = mip_s;
            12'hF14: rdata_s = HART_ID;
`ifdef CSR_COUNTERS_EN
            12'hB00: rdata_s = mcycle_r[31:0];
            12'hB80: rdata_s = mcycle_r[63:32];
            12'hB02: rdata_s = minstret_r[31:0];
            12'hB82: rdata_s = minstret_r[63:32];
`else
            12'hB00, 12'hB80, 12'hB02, 12'hB82: rdata_s = 32'h0000_0000;
`endif
            default: begin
                rdata_s   = 32'h0000_0000;
                addr_ok_s = 1'b0;
            end
        endcase
    end

    assign bus.csr_rdata = rdata_s;
    assign src_s = bus.func3[2] ? {27'h000_0000, bus.rs1} : bus.reg1;

    // Write intent and new value for the CSR op (RW / set / clear)
    always_comb begin
        write_attempt_s = 1'b0;
        wdata_s         = rdata_s;
        case (bus.func3[1:0])
            2'b01: begin
                write_attempt_s = 1'b1;
                wdata_s         = src_s;
            end
            2'b10: begin
                write_attempt_s = (bus.rs1 != 5'd0);
                wdata_s         = rdata_s | src_s;
            end
            2'b11: begin
                write_attempt_s = (bus.rs1 != 5'd0);
                wdata_s         = rdata_s & ~src_s;
            end
            default: begin
                write_attempt_s = 1'b0;
                wdata_s         = rdata_s;
            end
        endcase
    end

    assign illegal_s       = bus.csr_we && (!addr_ok_s || (write_attempt_s && (bus.csr_addr[11:10] == 2'b11)));
    assign bus.illegal_csr = illegal_s;
    assign commit_s        = pipeline_en && bus.csr_we && write_attempt_s && !illegal_s && !trap_s;

    // CSR and trap state: reset > trap > mret > CSR write
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_r          <= 32'h0000_0000;
            mtvec_r        <= MTVEC_RESET;
            mscratch_r     <= 32'h0000_0000;
            mepc_r         <= 32'h0000_0000;
            mcause_r       <= 32'h0000_0000;
            mtval_r        <= 32'h0000_0000;
        end else if (trap_s) begin
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
            mepc_r         <= pc;
            mcause_r       <= trap_cause_s;
            mtval_r        <= trap_val_s;
        end else begin
            if (pipeline_en && mret) begin
                mstatus_mie_r  <= mstatus_mpie_r;
                mstatus_mpie_r <= 1'b1;
            end else if (commit_s && (bus.csr_addr == 12'h300)) begin
                mstatus_mie_r  <= wdata_s[3];
                mstatus_mpie_r <= wdata_s[7];
            end
            if (commit_s) begin
                case (bus.csr_addr)
                    12'h304: mie_r      <= wdata_s & MIE_MASK;
                    12'h305: mtvec_r    <= {wdata_s[31:2], 1'b0, (wdata_s[1:0] == 2'b01)};
                    12'h340: mscratch_r <= wdata_s;
                    12'h341: mepc_r     <= {wdata_s[31:2], 2'b00};
                    12'h342: mcause_r   <= wdata_s;
                    12'h343: mtval_r    <= wdata_s;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // Cycle counter: free-running, a half write replaces it and skips the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_r <= 64'd0;
        end else if (commit_s && (bus.csr_addr == 12'hB00)) begin
            mcycle_r[31:0] <= wdata_s;
        end else if (commit_s && (bus.csr_addr == 12'hB80)) begin
            mcycle_r[63:32] <= wdata_s;
        end else begin
            mcycle_r <= mcycle_r + 64'd1;
        end
    end

    // Retired-instruction counter: counts non-trapping retirements
    always_ff @(posedge clk) begin
        if (rst) begin
            minstret_r <= 64'd0;
        end else if (commit_s && (bus.csr_addr == 12'hB02)) begin
            minstret_r[31:0] <= wdata_s;
        end else if (commit_s && (bus.csr_addr == 12'hB82)) begin
            minstret_r[63:32] <= wdata_s;
        end else if (pipeline_en && instr_retire && !trap_s) begin
            minstret_r <= minstret_r + 64'd1;
        end else begin
            minstret_r <= minstret_r;
        end
    end
`else
    logic unused_retire_s;
    assign unused_retire_s = instr_retire;
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed test of csr_trap_unit: CSR access/WARL, illegal detection,
// exceptions, interrupts, mret, reset mid-trap and (if built) counters.
module tb_csr_trap_unit;

    localparam logic [2:0] F_RW  = 3'b001;
    localparam logic [2:0] F_RS  = 3'b010;
    localparam logic [2:0] F_RWI = 3'b101;
    localparam logic [2:0] F_RSI = 3'b110;
    localparam logic [2:0] F_RCI = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipeline_en;
    logic [31:0] pc;
    logic        ecall, ebreak, mret, instr_retire;
    logic        irq_ext, irq_timer;
    logic [3:0]  irq_local;
    logic        trap_taken;
    logic [31:0] trap_target;
    logic [31:0] mret_target;

    int vec_cnt = 0;
    int err_cnt = 0;

    csr_trap_if bus_if();

    csr_trap_unit #(
        .HART_ID      (32'h0000_0003),
        .MTVEC_RESET  (32'h0000_0000),
        .NUM_LOCAL_IRQ(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if.slave),
        .pipeline_en (pipeline_en),
        .pc          (pc),
        .ecall       (ecall),
        .ebreak      (ebreak),
        .mret        (mret),
        .instr_retire(instr_retire),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .irq_local   (irq_local),
        .trap_taken  (trap_taken),
        .trap_target (trap_target),
        .mret_target (mret_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r, input logic [31:0] v);
        bus_if.func3    = f3;
        bus_if.csr_addr = a;
        bus_if.rs1      = r;
        bus_if.reg1     = v;
        bus_if.csr_we   = 1'b1;
        #1;
        tick();
        bus_if.csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus_if.csr_we   = 1'b0;
        bus_if.csr_addr = a;
        #1;
        chk(tag, bus_if.csr_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; pipeline_en = 1'b1; pc = 32'h0;
        ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; instr_retire = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_local = 4'h0;
        bus_if.csr_we = 1'b0; bus_if.func3 = 3'b000; bus_if.rs1 = 5'd0;
        bus_if.reg1 = 32'h0; bus_if.csr_addr = 12'h300;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        chk("rst_trap", {31'h0, trap_taken}, 32'h0);
        chk("rst_illegal", {31'h0, bus_if.illegal_csr}, 32'h0);
        rd_chk("rst_mtvec", 12'h305, 32'h0000_0000);
        rd_chk("rst_mie", 12'h304, 32'h0000_0000);

        // mtvec WARL mode bits
        csr_op(F_RW, 12'h305, 5'd1, 32'h8000_0101);
        rd_chk("mtvec_vec", 12'h305, 32'h8000_0101);
        csr_op(F_RW, 12'h305, 5'd1, 32'h8000_0102);
        rd_chk("mtvec_warl", 12'h305, 32'h8000_0100);

        // No-write rule and read-only faults
        bus_if.func3 = F_RS; bus_if.csr_addr = 12'h300; bus_if.rs1 = 5'd0;
        bus_if.reg1 = 32'hFFFF_FFFF; bus_if.csr_we = 1'b1; #1;
        chk("rs_x0_illegal", {31'h0, bus_if.illegal_csr}, 32'h0);
        tick(); bus_if.csr_we = 1'b0;
        rd_chk("rs_x0_nowrite", 12'h300, 32'h0000_1800);
        bus_if.func3 = F_RW; bus_if.csr_addr = 12'hF14; bus_if.rs1 = 5'd1;
        bus_if.reg1 = 32'h0000_0055; bus_if.csr_we = 1'b1; #1;
        chk("hartid_wr_illegal", {31'h0, bus_if.illegal_csr}, 32'h1);
        bus_if.func3 = F_RS; bus_if.rs1 = 5'd0; #1;
        chk("hartid_rs0_legal", {31'h0, bus_if.illegal_csr}, 32'h0);
        bus_if.csr_addr = 12'h7C0; #1;
        chk("unimpl_illegal", {31'h0, bus_if.illegal_csr}, 32'h1);
        bus_if.csr_we = 1'b0;
        rd_chk("hartid", 12'hF14, 32'h0000_0003);

        // ecall: trap blocks concurrent CSR write
        csr_op(F_RW, 12'h305, 5'd1, 32'h0000_0200);
        csr_op(F_RSI, 12'h300, 5'd8, 32'h0);
        rd_chk("mie_set", 12'h300, 32'h0000_1808);
        csr_op(F_RW, 12'h340, 5'd1, 32'hA5A5_A5A5);
        pc = 32'h0000_0100; ecall = 1'b1;
        bus_if.func3 = F_RW; bus_if.csr_addr = 12'h340; bus_if.rs1 = 5'd1;
        bus_if.reg1 = 32'h0000_1234; bus_if.csr_we = 1'b1; #1;
        chk("ecall_trap", {31'h0, trap_taken}, 32'h1);
        chk("ecall_target", trap_target, 32'h0000_0200);
        tick(); ecall = 1'b0; bus_if.csr_we = 1'b0;
        rd_chk("ecall_mscratch", 12'h340, 32'hA5A5_A5A5);
        rd_chk("ecall_mepc", 12'h341, 32'h0000_0100);
        rd_chk("ecall_mcause", 12'h342, 32'd11);
        rd_chk("ecall_mtval", 12'h343, 32'h0);
        rd_chk("ecall_mstatus", 12'h300, 32'h0000_1880);
        chk("mret_target", mret_target, 32'h0000_0100);
        mret = 1'b1; #1;
        chk("mret_notrap", {31'h0, trap_taken}, 32'h0);
        tick(); mret = 1'b0;
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

        // Vectored interrupt, ext beats timer
        csr_op(F_RW, 12'h305, 5'd1, 32'h0000_0201);
        csr_op(F_RW, 12'h304, 5'd1, 32'hFFFF_FFFF);
        rd_chk("mie_mask", 12'h304, 32'h000F_0888);
        csr_op(F_RW, 12'h304, 5'd1, 32'h0000_0880);
        pc = 32'h0000_0300; irq_ext = 1'b1; irq_timer = 1'b1;
        rd_chk("mip_view", 12'h344, 32'h0000_0880);
        chk("irq_trap", {31'h0, trap_taken}, 32'h1);
        chk("irq_target", trap_target, 32'h0000_022C);
        tick(); irq_ext = 1'b0; irq_timer = 1'b0;
        rd_chk("irq_mcause", 12'h342, 32'h8000_000B);
        rd_chk("irq_mepc", 12'h341, 32'h0000_0300);
        rd_chk("irq_mstatus", 12'h300, 32'h0000_1880);
        mret = 1'b1; tick(); mret = 1'b0;
        rd_chk("irq_mret_mstatus", 12'h300, 32'h0000_1888);
        csr_op(F_RW, 12'h341, 5'd1, 32'h0000_0123);
        rd_chk("mepc_warl", 12'h341, 32'h0000_0120);

        // ebreak beats a pending local interrupt
        csr_op(F_RW, 12'h304, 5'd1, 32'h0001_0000);
        pc = 32'h0000_0400; ebreak = 1'b1; irq_local = 4'b0001; #1;
        chk("ebrk_trap", {31'h0, trap_taken}, 32'h1);
        chk("ebrk_target", trap_target, 32'h0000_0200);
        tick(); ebreak = 1'b0; #1;
        chk("ebrk_masked", {31'h0, trap_taken}, 32'h0);
        rd_chk("ebrk_mcause", 12'h342, 32'd3);
        rd_chk("ebrk_mtval", 12'h343, 32'h0000_0400);
        mret = 1'b1; tick(); mret = 1'b0; #1;
        chk("local_target", trap_target, 32'h0000_0240);
        chk("local_trap", {31'h0, trap_taken}, 32'h1);
        tick(); irq_local = 4'h0;
        rd_chk("local_mcause", 12'h342, 32'h8000_0010);
        csr_op(F_RSI, 12'h300, 5'd8, 32'h0);
        csr_op(F_RCI, 12'h300, 5'd8, 32'h0);
        rd_chk("rci_mstatus", 12'h300, 32'h0000_1880);

        // Stalled stage: no trap, illegal still reported
        csr_op(F_RSI, 12'h300, 5'd8, 32'h0);
        pipeline_en = 1'b0; irq_local = 4'b0001;
        bus_if.func3 = F_RWI; bus_if.csr_addr = 12'hF14; bus_if.rs1 = 5'd3;
        bus_if.csr_we = 1'b1; #1;
        chk("stall_notrap", {31'h0, trap_taken}, 32'h0);
        chk("stall_illegal", {31'h0, bus_if.illegal_csr}, 32'h1);
        tick(); bus_if.csr_we = 1'b0; irq_local = 4'h0; pipeline_en = 1'b1;

        // Reset asserted together with a trap
        pc = 32'h0000_0500; ecall = 1'b1; rst = 1'b1;
        tick(); rst = 1'b0; ecall = 1'b0;
        rd_chk("rst2_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("rst2_mepc", 12'h341, 32'h0);
        rd_chk("rst2_mcause", 12'h342, 32'h0);
        rd_chk("rst2_mtvec", 12'h305, 32'h0);
        rd_chk("rst2_mie", 12'h304, 32'h0);
        rd_chk("rst2_mscratch", 12'h340, 32'h0);

`ifdef CSR_COUNTERS_EN
        rd_chk("rst2_mcycle", 12'hB00, 32'h0);
        csr_op(F_RW, 12'hB00, 5'd1, 32'hFFFF_FFFF);
        csr_op(F_RW, 12'hB80, 5'd1, 32'hFFFF_FFFF);
        rd_chk("mcycle_hold_lo", 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd_chk("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd_chk("mcycle_wrap_hi", 12'hB80, 32'h0);
        instr_retire = 1'b1;
        csr_op(F_RW, 12'hB02, 5'd1, 32'hFFFF_FFFF);
        csr_op(F_RW, 12'hB82, 5'd1, 32'hFFFF_FFFF);
        rd_chk("minstret_hold", 12'hB02, 32'hFFFF_FFFF);
        tick(); instr_retire = 1'b0;
        rd_chk("minstret_wrap_lo", 12'hB02, 32'h0);
        rd_chk("minstret_wrap_hi", 12'hB82, 32'h0);
`else
        bus_if.func3 = F_RW; bus_if.csr_addr = 12'hB00; bus_if.rs1 = 5'd1;
        bus_if.reg1 = 32'h0000_0055; bus_if.csr_we = 1'b1; #1;
        chk("cnt_off_illegal", {31'h0, bus_if.illegal_csr}, 32'h0);
        tick(); bus_if.csr_we = 1'b0;
        rd_chk("cnt_off_read", 12'hB00, 32'h0);
        rd_chk("cnt_off_read_hi", 12'hB82, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
